injection_scheduler: RTL

- Shares one injector pulse-width timer among all cylinders.
- Captures per-cylinder injection requests (rising edges of allow_injection from stroke_transition) and grants them round-robin.
- Drives each cylinder's injector output high for a programmed number of clk cycles.
- Sits between stroke_transition and the injector driver pads, gated by the engine on signal.

---
 rtl/hust_efi_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/injection_scheduler.sv | 138 +++++++++++++
 3 files changed

// File: rtl/hust_efi_pkg.sv
// Shared types and constants for the EFI scheduling blocks.
// CFG_CYLINDERS sets the cylinder count and defaults to 4 when the build does not define it.
`ifndef CFG_CYLINDERS
`define CFG_CYLINDERS 4
`endif

package hust_efi_pkg;

  // The GAP encoding is unused when the dead-time feature is compiled out.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } inj_state_t;

  localparam int unsigned INJ_ID_W = $clog2(`CFG_CYLINDERS);

  // 2 us at 125 MHz
  localparam int unsigned DEAD_CYCLES_DEF = 250;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Selects the first asserted request at or after ptr, wrapping from N-1 back to 0.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int unsigned W = $clog2(N);

  // Scan from the farthest candidate to the nearest so the nearest requester wins.
  always_comb begin
    int j;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % int'(N);
      if (req[j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = j[W-1:0];
      end
    end
  end

endmodule

// File: rtl/injection_scheduler.sv
// Shares one pulse-width timer among all cylinders.
// Rising edges of allow_injection are captured and granted round-robin.
// Each grant drives one injector high for pulse_width cycles.
// When CFG_INJ_DEADTIME_EN is defined, a GAP of DEAD_CYCLES idle cycles follows every nonzero pulse.
module injection_scheduler
  import hust_efi_pkg::*;
#(
  parameter int unsigned NUM_CYL  = `CFG_CYLINDERS,
  parameter int unsigned PW_WIDTH = 20
`ifdef CFG_INJ_DEADTIME_EN
  ,
  parameter int unsigned DEAD_CYCLES = DEAD_CYCLES_DEF
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       on,
  input  logic [NUM_CYL-1:0]         allow_injection,
  input  logic [PW_WIDTH-1:0]        pulse_width,
  output logic [NUM_CYL-1:0]         inj_out,
  output logic                       busy,
  output logic [$clog2(NUM_CYL)-1:0] grant_id,
  output logic [NUM_CYL-1:0]         overrun
);

  localparam int unsigned IdW = $clog2(NUM_CYL);

  inj_state_t          state_q, state_d;
  logic [PW_WIDTH-1:0] cnt_q, cnt_d;
  logic [IdW-1:0]      ptr_q, ptr_d;
  logic [IdW-1:0]      gid_q, gid_d;
  logic [NUM_CYL-1:0]  prev_allow_q;
  logic [NUM_CYL-1:0]  pending_q, pending_d;
  logic [NUM_CYL-1:0]  overrun_q, overrun_d;
  logic [NUM_CYL-1:0]  rise, clr, hit;
  logic                gnt_valid;
  logic [IdW-1:0]      gnt_idx;

  // Rises are ignored entirely while the engine is off.
  assign rise = {NUM_CYL{on}} & allow_injection & ~prev_allow_q;

  rr_arbiter #(
    .N(NUM_CYL)
  ) u_arb (
    .req      (pending_q),
    .ptr      (ptr_q),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  // Sequencer: grant, then pulse countdown, then optional dead time.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    clr     = '0;
    if (!on) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            state_d      = GRANT;
            gid_d        = gnt_idx;
            ptr_d        = (gnt_idx == IdW'(NUM_CYL - 1)) ? '0 : gnt_idx + IdW'(1);
            cnt_d        = pulse_width;
            clr[gnt_idx] = 1'b1;
          end
        end
        // A zero pulse width consumes the request without driving the injector.
        GRANT: state_d = (cnt_q == '0) ? IDLE : PULSE;
        PULSE: begin
          if (cnt_q <= PW_WIDTH'(1)) begin
`ifdef CFG_INJ_DEADTIME_EN
            state_d = GAP;
            cnt_d   = PW_WIDTH'(DEAD_CYCLES);
`else
            state_d = IDLE;
            cnt_d   = '0;
`endif
          end else begin
            cnt_d = cnt_q - PW_WIDTH'(1);
          end
        end
`ifdef CFG_INJ_DEADTIME_EN
        GAP: begin
          if (cnt_q <= PW_WIDTH'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - PW_WIDTH'(1);
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // Request capture: a second rise on a cylinder that is already queued or pulsing is merged.
  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(NUM_CYL); i++) begin
      hit[i] = rise[i] & (pending_q[i] | ((state_q == PULSE) && (gid_q == IdW'(i))));
    end
    pending_d = on ? ((pending_q & ~clr) | (rise & ~hit)) : '0;
    overrun_d = overrun_q | hit;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ptr_q        <= '0;
      gid_q        <= '0;
      prev_allow_q <= '0;
      pending_q    <= '0;
      overrun_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      gid_q        <= gid_d;
      prev_allow_q <= allow_injection;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
    end
  end

  assign inj_out  = (state_q == PULSE) ? (NUM_CYL'(1) << gid_q) : '0;
  assign busy     = (state_q != IDLE);
  assign grant_id = gid_q;
  assign overrun  = overrun_q;

endmodule
